// File: rtl/vms_pkg.sv
// rtl/vms_pkg.sv - shared types and constants for the VME strobe master
// Purpose: FSM state encoding and data constants used by vme_strobe_master.
// Ports: none (package).
package vms_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        RSP
    } vms_state_t;

    localparam int          VMS_DATA_W   = 32;
    localparam logic [31:0] VMS_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/vms_timeout.sv
// rtl/vms_timeout.sv - wait-state counter that flags an abandoned bank access
// Purpose: counts enabled cycles after a clear; o_expired is high on the enabled
//          cycle in which the count has reached TIMEOUT_CYC-1.
// Ports:
//   clk        in  clock
//   rst_n      in  synchronous active-low reset
//   i_clear    in  zero the counter (held during the strobe cycle)
//   i_enable   in  count this cycle (high while waiting for Done)
//   o_expired  out wait budget used up this cycle
module vms_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                 CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_expired = i_enable & w_at_last;

    // Saturates at LAST so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vme_strobe_master.sv
// rtl/vme_strobe_master.sv - host-to-register-bank strobe/done bus master
// Purpose: takes one host request at a time, issues a one-cycle RdMem/WrMem
//          strobe, waits for the matching Done and returns a response.
//          Optional wait-state timeout enabled by defining VMS_TIMEOUT_EN.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata               host request channel
//   rsp_valid/rsp_ready/rsp_rdata/
//   rsp_err                          host response channel
//   spurious_o/spurious_clr          sticky unexpected-Done flag and its clear
//   VMEAddr/VMEWrData/VMERdMem/
//   VMEWrMem                         bank request side
//   VMERdData/VMERdDone/VMEWrDone    bank completion side
module vme_strobe_master
    import vms_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [VMS_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [VMS_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  spurious_o,
    input  logic                  spurious_clr,
    output logic [ADDR_W-1:0]     VMEAddr,
    output logic [VMS_DATA_W-1:0] VMEWrData,
    output logic                  VMERdMem,
    output logic                  VMEWrMem,
    input  logic [VMS_DATA_W-1:0] VMERdData,
    input  logic                  VMERdDone,
    input  logic                  VMEWrDone
);

    vms_state_t            r_state;
    vms_state_t            w_state_nxt;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [VMS_DATA_W-1:0] r_wdata;
    logic [VMS_DATA_W-1:0] r_rdata;
    logic                  r_spur;

    logic                  w_accept;
    logic                  w_done_match;
    logic                  w_expired;
    logic                  w_rd_expected;
    logic                  w_wr_expected;
    logic                  w_spur_evt;

    assign w_accept      = (r_state == IDLE) & req_valid;
    assign w_rd_expected = (r_state == WAIT) & ~r_we;
    assign w_wr_expected = (r_state == WAIT) &  r_we;
    assign w_done_match  = (w_rd_expected & VMERdDone) | (w_wr_expected & VMEWrDone);
    // Any Done the current state is not waiting for is ignored and flagged,
    // including the non-matching half of a simultaneous RdDone/WrDone pair.
    assign w_spur_evt    = (VMERdDone & ~w_rd_expected) | (VMEWrDone & ~w_wr_expected);

`ifdef VMS_TIMEOUT_EN
    logic r_err;

    vms_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state == STROBE),
        .i_enable  (r_state == WAIT),
        .o_expired (w_expired)
    );

    // A Done arriving on the expiry cycle still completes normally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_done_match) begin
            r_err <= 1'b0;
        end else if (w_expired) begin
            r_err <= 1'b1;
        end
    end

    assign rsp_err = r_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYC > 1) & (&VMS_ERR_DATA);
    assign w_expired    = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (req_valid) w_state_nxt = STROBE;
            STROBE:  w_state_nxt = WAIT;
            WAIT:    if (w_done_match || w_expired) w_state_nxt = RSP;
            RSP:     if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request fields are only reloaded on acceptance, so the bank address and
    // write data hold their last value through IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_done_match) begin
            r_rdata <= r_we ? '0 : VMERdData;
        end else if (w_expired) begin
            r_rdata <= VMS_ERR_DATA;
        end
    end

    // Set has priority over clear so no event is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_spur <= 1'b0;
        end else if (w_spur_evt) begin
            r_spur <= 1'b1;
        end else if (spurious_clr) begin
            r_spur <= 1'b0;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RSP);
    assign rsp_rdata  = r_rdata;
    assign spurious_o = r_spur;
    assign VMEAddr    = r_addr;
    assign VMEWrData  = r_wdata;
    assign VMERdMem   = (r_state == STROBE) & ~r_we;
    assign VMEWrMem   = (r_state == STROBE) &  r_we;

endmodule

// File: tb/tb_vme_strobe_master.sv
// tb/tb_vme_strobe_master.sv - self-checking bench for vme_strobe_master
module tb_vme_strobe_master;

    localparam int ADDR_W      = 8;
    localparam int TIMEOUT_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    logic              spurious_o, spurious_clr;
    logic [ADDR_W-1:0] VMEAddr;
    logic [31:0]       VMEWrData, VMERdData;
    logic              VMERdMem, VMEWrMem, VMERdDone, VMEWrDone;

    int n_checks = 0;
    int n_errors = 0;

    vme_strobe_master #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .spurious_o   (spurious_o),
        .spurious_clr (spurious_clr),
        .VMEAddr      (VMEAddr),
        .VMEWrData    (VMEWrData),
        .VMERdMem     (VMERdMem),
        .VMEWrMem     (VMEWrMem),
        .VMERdData    (VMERdData),
        .VMERdDone    (VMERdDone),
        .VMEWrDone    (VMEWrDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        int                k;         // cycle (strobe = 0) of matching Done, -1 = never
        logic [31:0]       sdata;
        int                sp_at;     // cycle of the opposite-type Done, -1 = never
        int                hold;      // cycles rsp_ready stays low with req_valid high
        int                exp_lat;   // strobe-to-rsp_valid cycles
        logic [31:0]       exp_rdata;
        logic              exp_err;
        logic              exp_spur;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    function automatic vec_t mk(input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [31:0] wdata, input int k,
                                input logic [31:0] sdata, input int sp_at, input int hold,
                                input int lat, input logic [31:0] rdata,
                                input logic err, input logic spur);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.k = k; v.sdata = sdata;
        v.sp_at = sp_at; v.hold = hold; v.exp_lat = lat; v.exp_rdata = rdata;
        v.exp_err = err; v.exp_spur = spur;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic abort(input string name);
        n_errors++;
        $display("FAIL %s: no response within cycle budget", name);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    task automatic run_vec(input vec_t v);
        sb_t  e;
        int   t;
        logic got;
        chk("idle_req_ready", req_ready, 1);
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        sb.push_back(e);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        step();
        req_valid = 1'b0; req_addr = ~v.addr; req_wdata = 32'h0BAD_0BAD;
        t = 0; got = 1'b0;
        while (!got && t < 64) begin
            chk("rd_strobe", VMERdMem, (t == 0) && !v.we);
            chk("wr_strobe", VMEWrMem, (t == 0) &&  v.we);
            if (t == 0) begin
                chk("strobe_addr", VMEAddr, v.addr);
                chk("strobe_wdata", VMEWrData, v.wdata);
            end
            VMERdDone = ((t == v.k) && !v.we) || ((t == v.sp_at) &&  v.we);
            VMEWrDone = ((t == v.k) &&  v.we) || ((t == v.sp_at) && !v.we);
            VMERdData = (t == v.k) ? v.sdata : (32'hDEAD_BEEF ^ 32'(t));
            step();
            t++;
            VMERdDone = 1'b0; VMEWrDone = 1'b0;
            got = rsp_valid;
        end
        if (!got) abort("rsp_wait");
        if (sb.size() == 0) abort("scoreboard_empty");
        e = sb.pop_front();
        chk("latency", 32'(t), 32'(e.lat));
        for (int h = 0; h < v.hold; h++) begin
            req_valid = 1'b1;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_no_strobe", VMERdMem | VMEWrMem, 0);
            chk("hold_rdata", rsp_rdata, e.rdata);
            step();
        end
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_addr", VMEAddr, v.addr);
        chk("rsp_wdata", VMEWrData, v.wdata);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_no_strobe", VMERdMem | VMEWrMem, 0);
        chk("spurious", spurious_o, v.exp_spur);
        if (v.exp_spur) begin
            spurious_clr = 1'b1;
            step();
            spurious_clr = 1'b0;
            chk("spurious_cleared", spurious_o, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; spurious_clr = 1'b0; VMERdData = '0;
        VMERdDone = 1'b0; VMEWrDone = 1'b0;

        vecs.push_back(mk(1'b0, 8'h04, 32'h0,          1, 32'h0000_ABCD, -1, 0, 2, 32'h0000_ABCD, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h10, 32'h1234_5678,  2, 32'h0,         -1, 0, 3, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h08, 32'h0,          1, 32'h5A5A_0001, -1, 5, 2, 32'h5A5A_0001, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h0C, 32'h0,          3, 32'h0000_1111,  1, 0, 4, 32'h0000_1111, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 8'hFF, 32'h8000_0001,  1, 32'h0,          0, 0, 2, 32'h0,         1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h20, 32'h0,          2, 32'h0000_C0DE,  2, 0, 3, 32'h0000_C0DE, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 8'h00, 32'hFFFF_FFFF,  1, 32'h0,         -1, 0, 2, 32'h0,         1'b0, 1'b0));
`ifdef VMS_TIMEOUT_EN
        vecs.push_back(mk(1'b0, 8'h30, 32'h0,         -1, 32'h0,         -1, 0, 5, 32'hFFFF_FFFF, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h34, 32'h0,          4, 32'h0000_0044, -1, 0, 5, 32'h0000_0044, 1'b0, 1'b0));
`else
        vecs.push_back(mk(1'b0, 8'h30, 32'h0,         10, 32'h0000_0077, -1, 0, 11, 32'h0000_0077, 1'b0, 1'b0));
`endif

        step();
        step();
        rst_n = 1'b1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_spurious", spurious_o, 0);
        chk("rst_addr", VMEAddr, 0);
        chk("rst_wdata", VMEWrData, 0);
        chk("rst_strobes", VMERdMem | VMEWrMem, 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

`ifdef VMS_TIMEOUT_EN
        // Late Done after the timed-out read has already been answered.
        VMERdDone = 1'b1;
        step();
        VMERdDone = 1'b0;
        chk("late_done_spurious", spurious_o, 1);
        spurious_clr = 1'b1;
        step();
        spurious_clr = 1'b0;
`endif

        // Done in IDLE, then clear colliding with a new event, then a plain clear.
        VMERdDone = 1'b1;
        step();
        VMERdDone = 1'b0;
        chk("idle_done_spurious", spurious_o, 1);
        spurious_clr = 1'b1; VMEWrDone = 1'b1;
        step();
        VMEWrDone = 1'b0;
        chk("set_wins_over_clr", spurious_o, 1);
        step();
        spurious_clr = 1'b0;
        chk("clr_spurious", spurious_o, 0);

        // Reset pulse while waiting for a read Done.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40;
        step();
        req_valid = 1'b0;
        chk("rst_seq_strobe", VMERdMem, 1);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_addr", VMEAddr, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("midrst_no_rsp", rsp_valid, 0);
            chk("midrst_no_strobe", VMERdMem | VMEWrMem, 0);
        end
        run_vec(vecs[0]);

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
